// File: rtl/ula_pkg.sv
// Shared ULA video timing constants and the contention FSM state type.
package ula_pkg;

  localparam logic [8:0] H_TOTAL = 9'd448;
  localparam logic [8:0] V_TOTAL = 9'd312;
  localparam logic [8:0] DISP_H  = 9'd256;
  localparam logic [8:0] DISP_V  = 9'd192;
  localparam logic [8:0] INT_LEN = 9'd64;

  // Address page 0x4000-0x7FFF shares its RAM with the video fetch.
  localparam logic [1:0] CONT_PAGE = 2'b01;

  typedef enum logic {RUN, STALL} cont_state_t;

endpackage

// File: rtl/ula_video_counter.sv
// Horizontal/vertical beam counters, display window look-ahead and frame interrupt.
module ula_video_counter
  import ula_pkg::*;
(
  input  logic       clk_ula,
  input  logic       reset,
  output logic [8:0] hc,
  output logic [8:0] vc,
  output logic [8:0] hc_nxt,
  output logic       window_nxt,
  output logic       int_n
);

  logic [8:0] vc_nxt;

  // Next beam position; the contention FSM decides on it so its registered
  // outputs line up with the counter values they describe.
  always_comb begin
    hc_nxt = hc + 9'd1;
    vc_nxt = vc;
    if (hc == H_TOTAL - 9'd1) begin
      hc_nxt = 9'd0;
      vc_nxt = (vc == V_TOTAL - 9'd1) ? 9'd0 : vc + 9'd1;
    end
    window_nxt = (vc_nxt < DISP_V) && (hc_nxt < DISP_H);
  end

  always_ff @(posedge clk_ula or posedge reset) begin
    if (reset) begin
      hc    <= 9'd0;
      vc    <= 9'd0;
      int_n <= 1'b1;
    end else begin
      hc    <= hc_nxt;
      vc    <= vc_nxt;
      int_n <= !((vc_nxt == 9'd0) && (hc_nxt < INT_LEN));
    end
  end

endmodule

// File: rtl/ula_contention.sv
// ULA memory contention: stalls the CPU clock enable while the video fetch owns RAM.
// Define ULA_IO_CONTENTION_EN to also stall on even-port I/O cycles in the window.
module ula_contention
  import ula_pkg::*;
(
  input  logic        clk_ula,
  input  logic        reset,
  input  logic        cpu_turbo,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  output logic        cpu_ce,
  output logic [8:0]  hc,
  output logic [8:0]  vc,
  output logic        contended,
  output logic        int_n
);

  logic [8:0]  hc_nxt;
  logic        window_nxt;
  logic [2:0]  slot_nxt;
  logic        req_contended;
  logic        unused_bits;
  cont_state_t state;

  ula_video_counter u_counter (
    .clk_ula    (clk_ula),
    .reset      (reset),
    .hc         (hc),
    .vc         (vc),
    .hc_nxt     (hc_nxt),
    .window_nxt (window_nxt),
    .int_n      (int_n)
  );

  assign slot_nxt    = hc_nxt[3:1];
  assign unused_bits = ^{cpu_addr[13:0], cpu_iorq_n, hc_nxt[8:4]};

  always_comb begin
    req_contended = window_nxt && !cpu_mreq_n && (cpu_addr[15:14] == CONT_PAGE);
`ifdef ULA_IO_CONTENTION_EN
    req_contended = req_contended || (window_nxt && !cpu_iorq_n && !cpu_addr[0]);
`endif
  end

  // The request is only looked at on stall entry; the stall then runs to slot 6
  // regardless of what the bus does, unless turbo or the window end cuts it short.
  always_ff @(posedge clk_ula or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      cpu_ce    <= 1'b0;
      contended <= 1'b0;
    end else if (cpu_turbo) begin
      state     <= RUN;
      cpu_ce    <= 1'b1;
      contended <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (req_contended && hc_nxt[0] && (slot_nxt <= 3'd5)) begin
            state     <= STALL;
            cpu_ce    <= 1'b0;
            contended <= 1'b1;
          end else begin
            cpu_ce    <= hc_nxt[0];
            contended <= 1'b0;
          end
        end
        STALL: begin
          if (!window_nxt) begin
            state     <= RUN;
            cpu_ce    <= hc_nxt[0];
            contended <= 1'b0;
          end else if (hc_nxt[0] && (slot_nxt == 3'd6)) begin
            state     <= RUN;
            cpu_ce    <= 1'b1;
            contended <= 1'b0;
          end else begin
            cpu_ce    <= 1'b0;
            contended <= 1'b1;
          end
        end
        default: begin
          state     <= RUN;
          cpu_ce    <= 1'b0;
          contended <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_contention.sv
// Randomized bench for ula_contention against a beam-position / delay-table reference model.
module tb_ula_contention;
  import ula_pkg::*;

  logic        clk_ula = 1'b0;
  logic        reset;
  logic        cpu_turbo;
  logic [15:0] cpu_addr;
  logic        cpu_mreq_n;
  logic        cpu_iorq_n;
  logic        cpu_ce;
  logic [8:0]  hc;
  logic [8:0]  vc;
  logic        contended;
  logic        int_n;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: beam position plus a pending stall end position.
  int m_hc, m_vc, m_end_hc;
  bit m_ce, m_cont, m_int_n, m_stall;
  int delay_tbl[8] = '{6, 5, 4, 3, 2, 1, 0, 0};

  ula_contention dut (
    .clk_ula    (clk_ula),
    .reset      (reset),
    .cpu_turbo  (cpu_turbo),
    .cpu_addr   (cpu_addr),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_iorq_n (cpu_iorq_n),
    .cpu_ce     (cpu_ce),
    .hc         (hc),
    .vc         (vc),
    .contended  (contended),
    .int_n      (int_n)
  );

  always #5 clk_ula = ~clk_ula;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at vc=%0d hc=%0d: observed=%0d expected=%0d",
               tag, m_vc, m_hc, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("hc", hc, m_hc);
    checkOutput("vc", vc, m_vc);
    checkOutput("int_n", int_n, m_int_n);
    checkOutput("cpu_ce", cpu_ce, m_ce);
    checkOutput("contended", contended, m_cont);
  endtask

  task automatic modelReset();
    m_hc = 0; m_vc = 0; m_end_hc = 0;
    m_ce = 0; m_cont = 0; m_int_n = 1; m_stall = 0;
  endtask

  function automatic bit modelRequest(input bit win);
    bit r;
    r = win && !cpu_mreq_n && (cpu_addr[15:14] == 2'b01);
`ifdef ULA_IO_CONTENTION_EN
    r = r || (win && !cpu_iorq_n && !cpu_addr[0]);
`endif
    return r;
  endfunction

  // Predict the state after the coming rising edge from the current inputs.
  task automatic modelStep();
    int nh, nv, s;
    bit win;
    nh  = (m_hc + 1) % 448;
    nv  = (m_hc == 447) ? (m_vc + 1) % 312 : m_vc;
    win = (nv < 192) && (nh < 256);
    s   = (nh / 2) % 8;
    if (cpu_turbo) begin
      m_stall = 0;
      m_ce    = 1;
    end else if (m_stall) begin
      if (!win) begin
        m_stall = 0;
        m_ce    = nh % 2;
      end else if (nh == m_end_hc) begin
        m_stall = 0;
        m_ce    = 1;
      end else begin
        m_ce = 0;
      end
    end else if (modelRequest(win) && (nh % 2 == 1) && delay_tbl[s] > 0) begin
      m_stall  = 1;
      m_end_hc = nh + 2 * delay_tbl[s];
      m_ce     = 0;
    end else begin
      m_ce = nh % 2;
    end
    m_cont  = m_stall;
    m_int_n = !((nv == 0) && (nh < 64));
    m_hc    = nh;
    m_vc    = nv;
  endtask

  task automatic applyStimulus(input bit turbo, input bit mreq_n, input bit iorq_n,
                               input logic [15:0] addr);
    cpu_turbo  = turbo;
    cpu_mreq_n = mreq_n;
    cpu_iorq_n = iorq_n;
    cpu_addr   = addr;
    modelStep();
    @(negedge clk_ula);
    checkAll();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000);
  endtask

  task automatic advanceTo(input int line, input int col);
    for (int i = 0; i < 150000; i++) begin
      if (m_vc == line && m_hc == col) break;
      idleCycle();
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_hc", hc, 0);
    checkOutput("rst_vc", vc, 0);
    checkOutput("rst_cpu_ce", cpu_ce, 0);
    checkOutput("rst_contended", contended, 0);
    checkOutput("rst_int_n", int_n, 1);
    @(negedge clk_ula);
    reset = 1'b0;
  endtask

  initial begin
    int ce_count;
    int turbo_left;
    reset      = 1'b1;
    cpu_turbo  = 1'b0;
    cpu_addr   = 16'h0000;
    cpu_mreq_n = 1'b1;
    cpu_iorq_n = 1'b1;
    modelReset();
    repeat (3) @(negedge clk_ula);
    pulseReset();

    // One idle line: a CPU enable on every odd hc.
    advanceTo(1, 0);
    ce_count = 0;
    for (int i = 0; i < 448; i++) begin
      idleCycle();
      ce_count += int'(cpu_ce);
    end
    checkOutput("ce_per_line", ce_count, 224);

    // Slot 0 contended access: six T-state stall, released at hc 13.
    advanceTo(10, 0);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h4000);
      if (m_hc == 1) checkOutput("s0_contended", contended, 1);
      if (m_hc == 12) checkOutput("s0_ce_held", cpu_ce, 0);
      if (m_hc == 13) checkOutput("s0_release_ce", cpu_ce, 1);
    end

    // Slot 6 contended access: no stall.
    advanceTo(11, 12);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h4000);
    checkOutput("s6_ce", cpu_ce, 1);
    checkOutput("s6_contended", contended, 0);

    // Uncontended page in the window.
    advanceTo(12, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h8000);
    checkOutput("page8000_ce", cpu_ce, 1);
    checkOutput("page8000_contended", contended, 0);

    // Turbo asserted mid-stall.
    advanceTo(13, 0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 16'h4000);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h4000);
    checkOutput("turbo_ce", cpu_ce, 1);
    checkOutput("turbo_contended", contended, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h4000);
    checkOutput("turbo_ce_even", cpu_ce, 1);

    // Reset mid-stall.
    advanceTo(14, 0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 16'h4000);
    pulseReset();

    // Even-port I/O at slot 2: four T-state stall only when enabled.
    advanceTo(2, 4);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h00FE);
`ifdef ULA_IO_CONTENTION_EN
      if (m_hc == 5) checkOutput("io_contended", contended, 1);
      if (m_hc == 13) checkOutput("io_release_ce", cpu_ce, 1);
`else
      if (m_hc == 5) checkOutput("io_ignored", contended, 0);
`endif
    end

    // Randomized bus traffic with occasional turbo bursts and resets.
    turbo_left = 0;
    for (int i = 0; i < 15000; i++) begin
      if (turbo_left == 0 && $urandom_range(299, 0) == 0) turbo_left = $urandom_range(20, 1);
      if ($urandom_range(4999, 0) == 0) begin
        pulseReset();
      end else begin
        applyStimulus(turbo_left > 0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      16'($urandom()));
      end
      if (turbo_left > 0) turbo_left--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
